// File: rtl/iic_txn_ctrl.sv
// iic_txn_ctrl: expands single-byte register read/write commands into iic_core start/stop/rw/din pulse sequences.
// Optional watchdog per core operation enabled by defining IIC_TIMEOUT_EN.
module iic_txn_ctrl #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       ctrl_busy,
  output logic       iic_start,
  output logic       iic_stop,
  output logic       iic_rw,
  output logic [7:0] iic_din,
  input  logic       iic_busy,
  input  logic [7:0] iic_dout
);
  typedef enum logic [2:0] {IDLE, GAP, ISSUE, WAIT_HI, WAIT_LO, RESP, ABORT} state_t;
  if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("iic_txn_ctrl: GAP_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end
  state_t      state;
  logic        rd;
  logic [6:0]  dev;
  logic [7:0]  rg;
  logic [7:0]  wdata;
  logic [2:0]  step;
  logic [15:0] gap_cnt;
  logic        last;
  logic        is_stop;
  logic        op_rw;
  logic [7:0]  op_din;
  // Reads close with STOP and re-address with a fresh START; no repeated START.
  always_comb begin
    last    = rd ? step == 3'd5 : step == 3'd3;
    is_stop = rd ? (step == 3'd2 || step == 3'd5) : step == 3'd3;
    op_rw   = rd && step == 3'd4;
    op_din  = step == 3'd0 ? {dev, 1'b0} :
              step == 3'd1 ? rg :
              (!rd && step == 3'd2) ? wdata :
              (rd && step == 3'd3) ? {dev, 1'b1} : 8'h00;
  end
`ifdef IIC_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_hit;
  assign tmo_hit = tmo_cnt == 32'(TIMEOUT_CYCLES - 1);
`else
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      step      <= 3'd0;
      gap_cnt   <= 16'd0;
      rd        <= 1'b0;
      dev       <= 7'd0;
      rg        <= 8'd0;
      wdata     <= 8'd0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
      ctrl_busy <= 1'b0;
      iic_start <= 1'b0;
      iic_stop  <= 1'b0;
      iic_rw    <= 1'b0;
      iic_din   <= 8'd0;
`ifdef IIC_TIMEOUT_EN
      rsp_err   <= 1'b0;
      tmo_cnt   <= 32'd0;
`endif
    end else begin
      iic_start <= 1'b0;
      iic_stop  <= 1'b0;
      rsp_valid <= 1'b0;
`ifdef IIC_TIMEOUT_EN
      tmo_cnt   <= tmo_cnt + 32'd1;
`endif
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            rd        <= cmd_rw;
            dev       <= cmd_dev;
            rg        <= cmd_reg;
            wdata     <= cmd_wdata;
            step      <= 3'd0;
            gap_cnt   <= 16'd0;
            cmd_ready <= 1'b0;
            ctrl_busy <= 1'b1;
            state     <= GAP;
`ifdef IIC_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 16'd1;
          if (gap_cnt == 16'(GAP_CYCLES - 1)) state <= ISSUE;
        end
        ISSUE: if (!iic_busy) begin
          iic_start <= !is_stop;
          iic_stop  <= is_stop;
          iic_rw    <= op_rw;
          iic_din   <= op_din;
          state     <= WAIT_HI;
`ifdef IIC_TIMEOUT_EN
          tmo_cnt   <= 32'd0;
`endif
        end
        WAIT_HI: if (iic_busy) state <= WAIT_LO;
        WAIT_LO: if (!iic_busy) begin
          if (op_rw) rsp_rdata <= iic_dout;
          if (last) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            step    <= step + 3'd1;
            gap_cnt <= 16'd0;
            state   <= GAP;
          end
        end
        RESP: begin
          cmd_ready <= 1'b1;
          ctrl_busy <= 1'b0;
          state     <= IDLE;
        end
`ifdef IIC_TIMEOUT_EN
        // Best-effort bus release after a stuck operation; give up if busy never drops.
        ABORT: if (!iic_busy || tmo_hit) begin
          iic_stop  <= !iic_busy;
          iic_rw    <= 1'b0;
          iic_din   <= 8'd0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          state     <= RESP;
        end
`endif
        default: state <= IDLE;
      endcase
`ifdef IIC_TIMEOUT_EN
      if (tmo_hit && ((state == WAIT_HI && !iic_busy) || (state == WAIT_LO && iic_busy))) begin
        if (is_stop) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          state     <= RESP;
        end else begin
          tmo_cnt <= 32'd0;
          state   <= ABORT;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_iic_txn_ctrl.sv
// tb_iic_txn_ctrl: table-driven bench with an iic_core behavioural model and op/response scoreboards.
module tb_iic_txn_ctrl;
  localparam int GAP = 2, TMO = 64, BL = 20, BUD = 3000;
  typedef struct packed {logic stop; logic rw; logic [7:0] din;} op_t;
  typedef struct {logic rw; logic [6:0] dev; logic [7:0] rg, wd, rx; int pre; logic [7:0] exp; logic err;} vec_t;
  logic clock = 0, reset = 1, cmd_valid = 0, cmd_rw = 0;
  logic [6:0] cmd_dev = 0;
  logic [7:0] cmd_reg = 0, cmd_wdata = 0;
  logic cmd_ready, rsp_valid, rsp_err, ctrl_busy, iic_start, iic_stop, iic_rw;
  logic [7:0] rsp_rdata, iic_din;
  logic iic_busy = 0;
  logic [7:0] iic_dout = 0;
  int errors = 0, checks = 0, cyc = 0, since_done = 1000, ops_seen = 0, rsp_seen = 0, last_rsp_cyc = 0;
  int t = 0, pre_busy = 0, hang_from = 0;
  bit hang = 0, rx = 0, hang_now;
  logic [7:0] rx_byte = 0;
  op_t op_q[$], e;
  logic [8:0] rsp_q[$], r;
  vec_t vecs[6], v;
  int a, a2, tgt, s, base, n;
  iic_txn_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ctrl_busy(ctrl_busy), .iic_start(iic_start),
    .iic_stop(iic_stop), .iic_rw(iic_rw), .iic_din(iic_din), .iic_busy(iic_busy), .iic_dout(iic_dout)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  // Monitor runs before the core model so it sees the busy level the DUT sampled.
  always @(negedge clock) begin
    cyc++;
    since_done++;
    if (!reset) begin
      if (iic_start || iic_stop) begin
        ops_seen++;
        chk("pulse_excl", {31'd0, iic_start & iic_stop}, 0);
        chk("pulse_while_busy", {31'd0, iic_busy}, 0);
        chk("gap", {31'd0, since_done > GAP}, 1);
        chk("ctrl_busy_at_pulse", {31'd0, ctrl_busy}, 1);
        if (op_q.size() == 0) chk("op_unexpected", 1, 0);
        else begin
          e = op_q.pop_front();
          chk("op", iic_stop ? 32'h200 : {22'd0, 1'b0, iic_rw, iic_din}, e.stop ? 32'h200 : {22'd0, e});
        end
      end
      if (rsp_valid) begin
        rsp_seen++;
        last_rsp_cyc = cyc;
        if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          r = rsp_q.pop_front();
          chk("rsp", {23'd0, rsp_err, rsp_rdata}, {23'd0, r});
        end
      end
    end
    hang_now = hang && ops_seen >= hang_from;
    if (t > 0 && !(hang_now && t == 1)) begin
      t--;
      if (t == 0) begin
        since_done = 0;
        if (rx) begin
          iic_dout = rx_byte;
          rx = 0;
        end
      end
    end
    if (iic_start || iic_stop) begin
      t = BL + 2;
      rx = iic_start && iic_rw;
    end
    if (pre_busy > 0) pre_busy--;
    iic_busy = pre_busy > 0 || (t >= 1 && t <= BL);
  end
  task automatic tick();
    @(negedge clock);
    #1;
  endtask
  task automatic drive(input vec_t x);
    cmd_rw = x.rw; cmd_dev = x.dev; cmd_reg = x.rg; cmd_wdata = x.wd;
    rx_byte = x.rx; pre_busy = x.pre; cmd_valid = 1;
    op_q.push_back({1'b0, 1'b0, x.dev, 1'b0});
    op_q.push_back({1'b0, 1'b0, x.rg});
    if (!x.rw) begin
      op_q.push_back({1'b0, 1'b0, x.wd});
      op_q.push_back({1'b1, 9'd0});
    end else begin
      op_q.push_back({1'b1, 9'd0});
      op_q.push_back({1'b0, 1'b0, x.dev, 1'b1});
      op_q.push_back({1'b0, 1'b1, 8'h00});
      op_q.push_back({1'b1, 9'd0});
    end
    rsp_q.push_back({x.err, x.exp});
  endtask
  task automatic wait_accept(output int acc);
    int k = 0;
    while (!cmd_ready && k < BUD) begin
      tick();
      k++;
    end
    chk("accept_timeout", {31'd0, cmd_ready}, 1);
    acc = cyc;
    @(posedge clock);
    #1;
  endtask
  task automatic wait_rsp(input int target);
    int k = 0;
    while (rsp_seen < target && k < BUD) begin
      tick();
      k++;
    end
    chk("rsp_timeout", {31'd0, rsp_seen >= target}, 1);
  endtask
  task automatic run_one(input vec_t x);
    int acc, target;
    tick();
    target = rsp_seen + 1;
    drive(x);
    wait_accept(acc);
    cmd_valid = 0;
    wait_rsp(target);
    tick();
    chk("idle_after_rsp", {30'd0, cmd_ready, ctrl_busy}, 2);
    chk("ops_left", op_q.size(), 0);
  endtask
  initial begin
    vecs[0] = '{0, 7'h50, 8'h10, 8'hAA, 8'h00, 0,  8'h00, 0};
    vecs[1] = '{1, 7'h50, 8'h22, 8'h00, 8'h5C, 0,  8'h5C, 0};
    vecs[2] = '{0, 7'h3C, 8'h01, 8'hFF, 8'h00, 0,  8'h5C, 0};
    vecs[3] = '{1, 7'h7F, 8'hFF, 8'h00, 8'hA5, 10, 8'hA5, 0};
    vecs[4] = '{1, 7'h00, 8'h00, 8'h00, 8'h00, 0,  8'h00, 0};
    vecs[5] = '{0, 7'h7F, 8'h80, 8'h01, 8'h00, 10, 8'h00, 0};
    repeat (3) tick();
    chk("reset_outs", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, ctrl_busy, iic_start, iic_stop, iic_rw, iic_din}, 0);
    reset = 0;
    tick();
    chk("ready_after_reset", {31'd0, cmd_ready}, 1);
    chk("idle_outs", {rsp_valid, rsp_rdata, rsp_err, ctrl_busy, iic_start, iic_stop, iic_rw, iic_din}, 0);
    for (int i = 0; i < 6; i++) run_one(vecs[i]);
    tick();
    tgt = rsp_seen + 2;
    v = '{0, 7'h12, 8'h34, 8'h56, 8'h00, 0, 8'h00, 0};
    drive(v);
    wait_accept(a);
    v = '{1, 7'h50, 8'h22, 8'h00, 8'h5C, 0, 8'h5C, 0};
    drive(v);
    wait_accept(a2);
    chk("b2b_accept_cycle", a2, last_rsp_cyc + 1);
    cmd_valid = 0;
    wait_rsp(tgt);
    tick();
    chk("b2b_ops_left", op_q.size(), 0);
`ifdef IIC_TIMEOUT_EN
    tick();
    hang_from = ops_seen + 2;
    hang = 1;
    tgt = rsp_seen + 1;
    v = '{1, 7'h11, 8'h22, 8'h00, 8'h00, 0, 8'h5C, 1};
    drive(v);
    wait_accept(a);
    cmd_valid = 0;
    wait_rsp(tgt);
    chk("tmo_latency", {31'd0, (cyc - a) <= 2 * TMO + GAP + 64}, 1);
    op_q.delete();
    hang = 0;
    repeat (30) tick();
    chk("tmo_ready", {30'd0, cmd_ready, ctrl_busy}, 2);
`endif
    tick();
    v = '{1, 7'h50, 8'h22, 8'h00, 8'h77, 0, 8'h77, 0};
    base = ops_seen;
    drive(v);
    wait_accept(a);
    cmd_valid = 0;
    n = 0;
    while (ops_seen < base + 5 && n < BUD) begin
      tick();
      n++;
    end
    chk("reached_step4", ops_seen, base + 5);
    repeat (3) tick();
    reset = 1;
    s = rsp_seen;
    @(posedge clock);
    #1;
    chk("abort_outs", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, ctrl_busy, iic_start, iic_stop, iic_rw, iic_din}, 0);
    op_q.delete();
    rsp_q.delete();
    tick();
    reset = 0;
    repeat (30) tick();
    chk("no_rsp_after_abort", rsp_seen, s);
    v = '{0, 7'h01, 8'h02, 8'h03, 8'h00, 0, 8'h00, 0};
    run_one(v);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
